// File: rtl/mem_cfg_responder.sv
// Responder end of the switch memory configuration bus: per-port address registers,
// a read-only ID register, and a one-cycle ack after a configurable wait.
module mem_cfg_responder #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned ACK_LATENCY = 1,
    parameter logic [7:0]  ID_VAL      = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_sel_en,
    input  logic [7:0]             mem_addr,
    input  logic [7:0]             mem_wr_data,
    input  logic                   mem_wr_rd_s,
    output logic [7:0]             mem_rd_data,
    output logic                   mem_ack,
    output logic [NUM_PORTS*8-1:0] port_addr_cfg,
    output logic [NUM_PORTS-1:0]   cfg_wr_pulse
);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StRelease} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q;
    logic [7:0]           addr_q;
    logic [7:0]           data_q;
    logic                 wr_q;
    logic [7:0]           port_q [NUM_PORTS];
    logic [7:0]           rd_data_q;
    logic [NUM_PORTS-1:0] wr_pulse_q;

    logic                 commit;
    logic                 txn_wr;
    logic [7:0]           txn_addr;
    logic [7:0]           txn_data;
    logic [NUM_PORTS-1:0] port_hit;
    logic [7:0]           rd_val;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped request in WAIT wins over counter completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (mem_sel_en) begin
                    state_d = (ACK_LATENCY == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                if (!mem_sel_en) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd1) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!mem_sel_en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // With zero latency the commit edge is also the capture edge, so use the live bus.
    always_comb begin
        commit   = (state_d == StAck);
        txn_wr   = (state_q == StIdle) ? mem_wr_rd_s : wr_q;
        txn_addr = (state_q == StIdle) ? mem_addr    : addr_q;
        txn_data = (state_q == StIdle) ? mem_wr_data : data_q;
    end

    always_comb begin
        port_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_hit[i] = (txn_addr == 8'(i));
        end
    end

    always_comb begin
        rd_val = 8'h00;
        if (txn_addr == 8'hFF) begin
            rd_val = ID_VAL;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_hit[i]) begin
                rd_val = port_q[i];
            end
        end
    end

    // Capture, wait counter, register bank and ack-cycle outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            wr_q       <= 1'b0;
            rd_data_q  <= 8'h00;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_q[i] <= 8'h00;
            end
        end else begin
            if (state_q == StIdle && mem_sel_en) begin
                addr_q <= mem_addr;
                data_q <= mem_wr_data;
                wr_q   <= mem_wr_rd_s;
                cnt_q  <= 4'(ACK_LATENCY);
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 4'd1;
            end

            rd_data_q  <= 8'h00;
            wr_pulse_q <= '0;
            if (commit) begin
                if (txn_wr) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (port_hit[i]) begin
                            port_q[i]     <= txn_data;
                            wr_pulse_q[i] <= 1'b1;
                        end
                    end
                end else begin
                    rd_data_q <= rd_val;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        mem_ack       = (state_q == StAck);
        mem_rd_data   = rd_data_q;
        cfg_wr_pulse  = wr_pulse_q;
        port_addr_cfg = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_addr_cfg[8*i +: 8] = port_q[i];
        end
    end

endmodule

// File: tb/tb_mem_cfg_responder.sv
// Bench for mem_cfg_responder: a default instance (latency 1) and a latency-3 instance,
// directed table, corner sequences and random transactions against a register-map model.
module tb_mem_cfg_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        sel_a, wr_a, ack_a;
    logic [7:0]  addr_a, wdata_a, rd_a;
    logic [31:0] cfg_a;
    logic [3:0]  pulse_a;

    logic        sel_b, wr_b, ack_b;
    logic [7:0]  addr_b, wdata_b, rd_b;
    logic [31:0] cfg_b;
    logic [3:0]  pulse_b;

    int vectors     = 0;
    int miscompares = 0;

    mem_cfg_responder dut_a (
        .clk          (clk),
        .rst          (rst),
        .mem_sel_en   (sel_a),
        .mem_addr     (addr_a),
        .mem_wr_data  (wdata_a),
        .mem_wr_rd_s  (wr_a),
        .mem_rd_data  (rd_a),
        .mem_ack      (ack_a),
        .port_addr_cfg(cfg_a),
        .cfg_wr_pulse (pulse_a)
    );

    mem_cfg_responder #(
        .ACK_LATENCY(3)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .mem_sel_en   (sel_b),
        .mem_addr     (addr_b),
        .mem_wr_data  (wdata_b),
        .mem_wr_rd_s  (wr_b),
        .mem_rd_data  (rd_b),
        .mem_ack      (ack_b),
        .port_addr_cfg(cfg_b),
        .cfg_wr_pulse (pulse_b)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        logic [3:0]  exp_pulse;
        logic [31:0] exp_cfg;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    // Register-map model of the default instance
    logic [7:0] ref_regs [4];

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a < 8'd4) return ref_regs[a[1:0]];
        if (a == 8'hFF) return 8'hA5;
        return 8'h00;
    endfunction

    task automatic model_write(input logic wr, input logic [7:0] a, input logic [7:0] d);
        if (wr && a < 8'd4) ref_regs[a[1:0]] = d;
    endtask

    function automatic logic [31:0] model_cfg();
        return {ref_regs[3], ref_regs[2], ref_regs[1], ref_regs[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic sel, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
        if (which) begin
            sel_b = sel; wr_b = wr; addr_b = a; wdata_b = d;
        end else begin
            sel_a = sel; wr_a = wr; addr_a = a; wdata_a = d;
        end
    endtask

    function automatic logic get_ack(input bit which);
        return which ? ack_b : ack_a;
    endfunction
    function automatic logic [7:0] get_rd(input bit which);
        return which ? rd_b : rd_a;
    endfunction
    function automatic logic [3:0] get_pulse(input bit which);
        return which ? pulse_b : pulse_a;
    endfunction
    function automatic logic [31:0] get_cfg(input bit which);
        return which ? cfg_b : cfg_a;
    endfunction

    // One full handshake; lat counts edges from capture to the edge starting the ack cycle.
    // The bus is scrambled after capture, and quiet drops if rd/pulse/ack leak outside it.
    task automatic run_txn(input bit which, input logic wr, input logic [7:0] a,
                           input logic [7:0] d, output bit acked, output int lat,
                           output logic [7:0] rd, output logic [3:0] pulse,
                           output logic [31:0] cfg, output bit quiet);
        acked = 1'b0; lat = 0; quiet = 1'b1; rd = 8'h00; pulse = 4'h0; cfg = 32'h0;
        @(negedge clk);
        drive(which, 1'b1, wr, a, d);
        for (int n = 1; n <= 20 && !acked; n++) begin
            @(posedge clk); #1;
            if (get_ack(which)) begin
                acked = 1'b1; lat = n;
                rd = get_rd(which); pulse = get_pulse(which); cfg = get_cfg(which);
            end else if (get_rd(which) != 8'h00 || get_pulse(which) != 4'h0) begin
                quiet = 1'b0;
            end
            if (n == 1) drive(which, 1'b1, ~wr, ~a, ~d);
        end
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (get_ack(which) || get_rd(which) != 8'h00 || get_pulse(which) != 4'h0)
                quiet = 1'b0;
        end
    endtask

    // Latency-3 instance: request held for `hold` edges then dropped before completion.
    task automatic abort_seq(input int hold, input string tag);
        int acks_seen = 0;
        int pulses_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            drive(1'b1, (n < hold), 1'b1, 8'h00, 8'h77);
            @(posedge clk); #1;
            if (ack_b) acks_seen++;
            if (pulse_b != 4'h0) pulses_seen++;
        end
        check({tag, " acks"}, acks_seen, 0);
        check({tag, " pulses"}, pulses_seen, 0);
        check({tag, " port0"}, {24'h0, cfg_b[7:0]}, 32'h0);
    endtask

    bit          acked, quiet;
    int          lat, acks, pcnt;
    logic        rwr;
    logic [7:0]  raddr, rdata, exp_rd;
    logic [3:0]  exp_pulse;
    logic [7:0]  rd;
    logic [3:0]  pulse;
    logic [31:0] cfg;

    initial begin
        vt[0]  = '{1'b1, 8'h02, 8'h3C, 8'h00, 4'b0100, 32'h003C_0000};
        vt[1]  = '{1'b0, 8'h02, 8'h00, 8'h3C, 4'b0000, 32'h003C_0000};
        vt[2]  = '{1'b0, 8'hFF, 8'h00, 8'hA5, 4'b0000, 32'h003C_0000};
        vt[3]  = '{1'b1, 8'hFF, 8'h11, 8'h00, 4'b0000, 32'h003C_0000};
        vt[4]  = '{1'b0, 8'hFF, 8'h00, 8'hA5, 4'b0000, 32'h003C_0000};
        vt[5]  = '{1'b1, 8'h07, 8'h55, 8'h00, 4'b0000, 32'h003C_0000};
        vt[6]  = '{1'b0, 8'h07, 8'h00, 8'h00, 4'b0000, 32'h003C_0000};
        vt[7]  = '{1'b1, 8'h04, 8'h99, 8'h00, 4'b0000, 32'h003C_0000};
        vt[8]  = '{1'b0, 8'h00, 8'h00, 8'h00, 4'b0000, 32'h003C_0000};
        vt[9]  = '{1'b1, 8'h00, 8'h3C, 8'h00, 4'b0001, 32'h003C_003C};
        vt[10] = '{1'b1, 8'h00, 8'h3C, 8'h00, 4'b0001, 32'h003C_003C};
        vt[11] = '{1'b0, 8'h00, 8'h00, 8'h3C, 4'b0000, 32'h003C_003C};
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;

        // Reset held two cycles with a request pending on both instances
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'hFF);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d ack_a", c), {31'h0, ack_a}, 32'h0);
            check($sformatf("rst%0d cfg_a", c), cfg_a, 32'h0);
            check($sformatf("rst%0d rd_a", c), {24'h0, rd_a}, 32'h0);
            check($sformatf("rst%0d ack_b", c), {31'h0, ack_b}, 32'h0);
            check($sformatf("rst%0d cfg_b", c), cfg_b, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ack_a || ack_b) acks++;
        end
        check("post-rst idle acks", acks, 0);
        run_txn(1'b0, 1'b0, 8'h00, 8'h00, acked, lat, rd, pulse, cfg, quiet);
        check("fresh req ack", {31'h0, acked}, 32'h1);
        check("fresh req latency", lat, 2);
        check("fresh req rd", {24'h0, rd}, 32'h0);

        // Directed table on the default instance
        for (int i = 0; i < NV; i++) begin
            run_txn(1'b0, vt[i].wr, vt[i].addr, vt[i].data, acked, lat, rd, pulse, cfg, quiet);
            model_write(vt[i].wr, vt[i].addr, vt[i].data);
            check($sformatf("vec%0d ack", i), {31'h0, acked}, 32'h1);
            check($sformatf("vec%0d latency", i), lat, 2);
            check($sformatf("vec%0d rd", i), {24'h0, rd}, {24'h0, vt[i].exp_rd});
            check($sformatf("vec%0d pulse", i), {28'h0, pulse}, {28'h0, vt[i].exp_pulse});
            check($sformatf("vec%0d cfg", i), cfg, vt[i].exp_cfg);
            check($sformatf("vec%0d quiet", i), {31'h0, quiet}, 32'h1);
        end

        // Request held high for 10 cycles: exactly one transaction
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'h01, 8'h5A);
        acks = 0; pcnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ack_a) acks++;
            if (pulse_a[1]) pcnt++;
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (ack_a) acks++;
            if (pulse_a[1]) pcnt++;
        end
        model_write(1'b1, 8'h01, 8'h5A);
        check("held acks", acks, 1);
        check("held pulses", pcnt, 1);
        check("held cfg", cfg_a, 32'h003C_5A3C);

        // Latency-3 instance: aborts, including on the completing edge, then a full write
        abort_seq(2, "abort early");
        abort_seq(3, "abort at completion");
        run_txn(1'b1, 1'b1, 8'h02, 8'hC3, acked, lat, rd, pulse, cfg, quiet);
        check("lat3 ack", {31'h0, acked}, 32'h1);
        check("lat3 latency", lat, 4);
        check("lat3 pulse", {28'h0, pulse}, 32'h4);
        check("lat3 cfg", cfg, 32'h00C3_0000);
        check("lat3 quiet", {31'h0, quiet}, 32'h1);

        // Reset while the latency-3 instance waits
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'h01, 8'h44);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst ack", {31'h0, ack_b}, 32'h0);
        check("midrst cfg_b", cfg_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ack_b) acks++;
        end
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        check("midrst later acks", acks, 0);
        check("midrst cfg_b after", cfg_b, 32'h0);
        check("midrst cfg_a", cfg_a, model_cfg());
        run_txn(1'b1, 1'b0, 8'h01, 8'h00, acked, lat, rd, pulse, cfg, quiet);
        check("after midrst ack", {31'h0, acked}, 32'h1);
        check("after midrst latency", lat, 4);
        check("after midrst rd", {24'h0, rd}, 32'h0);

        // Random transactions on the default instance against the model
        for (int i = 0; i < 40; i++) begin
            rwr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0, 1:    raddr = 8'($urandom_range(0, 3));
                2:       raddr = 8'hFF;
                default: raddr = 8'($urandom);
            endcase
            rdata     = 8'($urandom);
            exp_rd    = rwr ? 8'h00 : model_read(raddr);
            exp_pulse = (rwr && raddr < 8'd4) ? (4'b0001 << raddr[1:0]) : 4'b0000;
            model_write(rwr, raddr, rdata);
            run_txn(1'b0, rwr, raddr, rdata, acked, lat, rd, pulse, cfg, quiet);
            check($sformatf("rand%0d ack", i), {31'h0, acked}, 32'h1);
            check($sformatf("rand%0d rd a=%0h", i, raddr), {24'h0, rd}, {24'h0, exp_rd});
            check($sformatf("rand%0d pulse", i), {28'h0, pulse}, {28'h0, exp_pulse});
            check($sformatf("rand%0d cfg", i), cfg, model_cfg());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_cfg_responder.md
Name: mem_cfg_responder

Overview:
- Responder end of the switch memory configuration bus. It sits inside the switch DUT behind the dut_mp side of the mem interface.
- Decodes initiator transactions (mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s) into a bank of per-port address registers plus a read-only ID register.
- Returns read data and a one-cycle mem_ack.
- Exports the configured port addresses to the switch forwarding logic.

Parameters:
- NUM_PORTS, 4: number of port-address registers, mapped at mem_addr 0x00..NUM_PORTS-1. Legal range 1..16.
- ACK_LATENCY, 1: extra wait cycles between capture and ack. Legal range 0..15.
- ID_VAL, 8'hA5: constant returned on a read of mem_addr 0xFF.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mem_sel_en  input  1  transaction request; held high by the initiator until mem_ack.
- mem_addr  input  8  register address.
- mem_wr_data  input  8  write data.
- mem_wr_rd_s  input  1  1 = write, 0 = read.
- mem_rd_data  output  8  read data; valid only in the mem_ack cycle of a read.
- mem_ack  output  1  one-cycle completion pulse.
- port_addr_cfg  output  NUM_PORTS*8  flattened port registers; port i occupies bits [8i+7:8i].
- cfg_wr_pulse  output  NUM_PORTS  one-cycle strobe per port register written.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset, on the first clk edge with rst=1:
  - State goes to IDLE.
  - mem_ack=0, mem_rd_data=8'h00, cfg_wr_pulse=0.
  - All port registers = 8'h00.
  - rst takes priority over every other event, including mid-transaction: no ack and no write complete, and the in-flight transaction is dropped.
- FSM states: IDLE, WAIT, ACK, RELEASE.
- IDLE:
  - On an edge with mem_sel_en=1, latch addr, wr_data and wr_rd_s into capture registers and load the wait counter with ACK_LATENCY.
  - Go to ACK if ACK_LATENCY=0, otherwise to WAIT.
  - Bus inputs are ignored after capture.
- WAIT:
  - Decrement the counter each cycle; go to ACK when the counter reaches 1.
  - If mem_sel_en=0 on any WAIT edge, the transaction aborts: go to IDLE, with no ack and no write.
- ACK, lasting exactly one cycle:
  - mem_ack=1 for the cycle.
  - The write commits on the edge entering ACK, so port_addr_cfg shows the new value in the ack cycle and cfg_wr_pulse[i]=1 in the same cycle.
  - Read data is registered on the same edge.
  - Next state is RELEASE.
- RELEASE:
  - Stay until mem_sel_en=0 is sampled, then go to IDLE.
  - A new request therefore needs sel_en low for at least one edge; a held-high sel_en never causes a second transaction.
- Latency: when sel_en is first sampled high at edge E, mem_ack is high in the cycle after edge E+ACK_LATENCY. Minimum 1 cycle; 2 cycles with the defaults.
- Address map:
  - 0x00..NUM_PORTS-1: read/write port registers.
  - 0xFF: read-only ID_VAL; writes are ignored but acked.
  - Any other address: reads return 8'h00, writes are ignored, ack is still given.
- mem_rd_data:
  - 8'h00 in every cycle except the ack cycle of a read.
  - During a write ack it is 8'h00.
- cfg_wr_pulse:
  - Fires only for an in-range port write.
  - Fires even when the written value equals the old value.
- No wrap-around: mem_addr is decoded as a full 8-bit compare, so address 0x04 with NUM_PORTS=4 is unmapped.
- Abort on the same edge the counter would complete: the abort wins. No ack and no write.

Test Plan:
1. Reset: hold rst for 2 cycles with sel_en=1 → mem_ack=0, port_addr_cfg=0, mem_rd_data=0 throughout; after release, a transaction starts only on a fresh sel_en assertion.
2. Write/read: write 8'h3C to addr 0x02, then read addr 0x02 → write ack 2 cycles after capture, cfg_wr_pulse=4'b0100 in the ack cycle, port_addr_cfg[23:16]=8'h3C; read ack returns mem_rd_data=8'h3C only in the ack cycle.
3. ID/unmapped: read 0xFF → 8'hA5. Write 8'h11 to 0xFF then read 0xFF → still 8'hA5. Write to 0x07 → acked, no cfg_wr_pulse, registers unchanged; read 0x07 → 8'h00.
4. Held request: keep sel_en=1 for 10 cycles after a write to 0x01 → exactly one mem_ack pulse and one cfg_wr_pulse[1].
5. Abort: ACK_LATENCY=3; assert write 8'h77 to 0x00, drop sel_en after 2 cycles → no ack, port 0 stays 8'h00.
6. Mid-op reset: assert rst in the WAIT state → no ack, registers 0, FSM in IDLE on the next cycle.
